// File: rtl/sample_read_arbiter.sv
// Round-robin share of the sample RAM read port among N_CONS consumers, bursts of up to BURST_LEN samples.
// Latency: grant registered two cycles after a request is seen in IDLE; data/valid/ready pass through combinationally.
// Backpressure: RAM ready follows the granted consumer's ready; optional stall watchdog under ARB_TIMEOUT_EN.
module sample_read_arbiter #(
    parameter int N_CONS    = 4,
    parameter int DATA_W    = 24,
    parameter int BURST_LEN = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] ram_read_data_i,
    input  logic              ram_read_valid_i,
    output logic              ram_read_ready_o,
    input  logic              ram_buffer_ready_i,
    input  logic [N_CONS-1:0] cons_req_i,
    input  logic [N_CONS-1:0] cons_ready_i,
    output logic [N_CONS-1:0] cons_valid_o,
    output logic [DATA_W-1:0] cons_data_o,
    output logic [N_CONS-1:0] grant_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int PTR_W = (N_CONS > 1) ? $clog2(N_CONS) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_BURST,
        ST_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [N_CONS-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_burst;
    logic               xfer;
    logic               stall_hit;
    logic [PTR_W-1:0]   cand [N_CONS];
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_vld;

    assign in_burst = (state_q == ST_BURST);
    assign xfer     = in_burst & ram_buffer_ready_i & ram_read_valid_i & cons_ready_i[gidx_q];

    // Scan requesters starting at ptr_q so a re-raised request waits its turn.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < N_CONS; i++) begin
            cand[i] = PTR_W'((int'(ptr_q) + i) % N_CONS);
            if (!pick_vld && cons_req_i[cand[i]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[i];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

    logic [STALL_W-1:0] stall_q, stall_d;

    assign stall_hit = in_burst && (stall_q == STALL_MAX);

    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_ARB) begin
            stall_d = '0;
        end else if (in_burst) begin
            if (xfer) begin
                stall_d = '0;
            end else if (ram_read_valid_i && (stall_q != STALL_MAX)) begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ram_buffer_ready_i && (|cons_req_i)) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (pick_vld) begin
                    grant_d = N_CONS'(1) << pick_idx;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_BURST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // The last sample is accepted in the same cycle the burst ends.
                if ((xfer && (cnt_q == CNT_LAST)) ||
                    (!xfer && !cons_req_i[gidx_q]) ||
                    !ram_buffer_ready_i ||
                    stall_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                grant_d = '0;
                ptr_d   = (gidx_q == PTR_LAST) ? '0 : gidx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ram_read_ready_o = in_burst & ram_buffer_ready_i & cons_ready_i[gidx_q];
    assign cons_valid_o     = grant_q & {N_CONS{in_burst & ram_buffer_ready_i & ram_read_valid_i}};
    assign cons_data_o      = ram_read_data_i;
    assign grant_o          = grant_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign timeout_o        = stall_hit;

endmodule

// File: tb/tb_sample_read_arbiter.sv
// Bench for sample_read_arbiter: vector table for the grant rotation plus hand sequences, scoreboarded transfers.
module tb_sample_read_arbiter;

    localparam int N  = 4;
    localparam int DW = 24;
    localparam int BL = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] ram_dat = 24'hFFFFFC;
    logic          ram_vld = 1'b0;
    logic          ram_rdy;
    logic          buf_rdy = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  rdy = '0;
    logic [N-1:0]  cv;
    logic [DW-1:0] cdat;
    logic [N-1:0]  grant;
    logic          busy;
    logic          tmo;

    sample_read_arbiter #(
        .N_CONS(N), .DATA_W(DW), .BURST_LEN(BL), .TIMEOUT(TO)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .ram_read_data_i    (ram_dat),
        .ram_read_valid_i   (ram_vld),
        .ram_read_ready_o   (ram_rdy),
        .ram_buffer_ready_i (buf_rdy),
        .cons_req_i         (req),
        .cons_ready_i       (rdy),
        .cons_valid_o       (cv),
        .cons_data_o        (cdat),
        .grant_o            (grant),
        .busy_o             (busy),
        .timeout_o          (tmo)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int            cons;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [N-1:0] req;
        logic         bufr;
        logic         vld;
        logic [N-1:0] rdy;
        logic [N-1:0] grant;
        logic         busy;
        logic         rr;
        logic [N-1:0] cv;
    } vec_t;

    exp_t          sb[$];
    logic [DW-1:0] exp_next = 24'hFFFFFC;
    vec_t          tbl[64];
    int            n_vec = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    logic          hs = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int c);
        exp_t e;
        e.cons = c;
        e.data = exp_next;
        sb.push_back(e);
        exp_next = exp_next + 1'b1;
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic monitor();
        logic [N-1:0] chs;
        exp_t         e;
        chs = cv & rdy;
        hs  = ram_vld & ram_rdy;
        if (hs || (chs != '0)) begin
            check("ram_vs_cons_handshake", {31'b0, |chs}, {31'b0, hs});
            if (hs) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_transfer: consumer %0d data %0h, none expected", oh_idx(chs), cdat);
                end else begin
                    e = sb.pop_front();
                    check("xfer_consumer", oh_idx(chs), e.cons);
                    check("xfer_data", cdat, e.data);
                end
            end
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        monitor();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
        if (hs) ram_dat = ram_dat + 1'b1;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic b, input logic v, input logic [N-1:0] rd);
        req     = r;
        buf_rdy = b;
        ram_vld = v;
        rdy     = rd;
    endtask

    task automatic add_row(input logic [N-1:0] r, input logic [N-1:0] g, input logic bsy,
                           input logic rr, input logic [N-1:0] c);
        tbl[n_vec].req   = r;
        tbl[n_vec].bufr  = 1'b1;
        tbl[n_vec].vld   = 1'b1;
        tbl[n_vec].rdy   = '1;
        tbl[n_vec].grant = g;
        tbl[n_vec].busy  = bsy;
        tbl[n_vec].rr    = rr;
        tbl[n_vec].cv    = c;
        n_vec++;
    endtask

    // One full grant cycle: IDLE, ARB, BL transfers, RELEASE.
    task automatic add_burst(input logic [N-1:0] r, input int g);
        logic [N-1:0] oh;
        oh = N'(1) << g;
        add_row(r, '0, 1'b0, 1'b0, '0);
        add_row(r, '0, 1'b1, 1'b0, '0);
        for (int i = 0; i < BL; i++) add_row(r, oh, 1'b1, 1'b1, oh);
        add_row(r, oh, 1'b1, 1'b0, '0);
    endtask

    task automatic idle_cycles(input int n);
        drive('0, 1'b1, 1'b1, '1);
        for (int i = 0; i < n; i++) begin
            cyc_begin();
            cyc_end();
        end
        cyc_begin();
        check("drained_idle", busy, 1'b0);
        cyc_end();
    endtask

    task automatic run_full_burst(input int g, input string tag);
        for (int i = 0; i < BL; i++) begin
            push(g);
            cyc_begin();
            check({tag, "_grant"}, grant, N'(1) << g);
            cyc_end();
        end
        cyc_begin();
        check({tag, "_release_ready"}, ram_rdy, 1'b0);
        cyc_end();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset holds outputs low even with every input asserted.
        drive('1, 1'b1, 1'b1, '1);
        #3;
        check("reset_grant", grant, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_ram_ready", ram_rdy, 1'b0);
        check("reset_cons_valid", cv, '0);
        check("reset_timeout", tmo, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Round-robin from reset, then a lone requester that keeps getting consumer 0.
        add_burst(4'b1111, 0);
        add_burst(4'b1111, 1);
        add_burst(4'b1111, 2);
        add_burst(4'b1111, 3);
        add_burst(4'b1111, 0);
        add_burst(4'b0001, 0);
        add_burst(4'b0001, 0);
        for (int k = 0; k < n_vec; k++) begin
            drive(tbl[k].req, tbl[k].bufr, tbl[k].vld, tbl[k].rdy);
            if (tbl[k].rr && tbl[k].vld) push(oh_idx(tbl[k].cv));
            cyc_begin();
            check($sformatf("vec%0d_grant", k), grant, tbl[k].grant);
            check($sformatf("vec%0d_busy", k), busy, tbl[k].busy);
            check($sformatf("vec%0d_ram_ready", k), ram_rdy, tbl[k].rr);
            check($sformatf("vec%0d_cons_valid", k), cv, tbl[k].cv);
            check($sformatf("vec%0d_timeout", k), tmo, 1'b0);
            cyc_end();
        end

        // Consumer 1 toggles ready: RAM ready must mirror it, samples stay in order.
        drive(4'b0010, 1'b1, 1'b1, '1);
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
        for (int k = 0; k < 7; k++) begin
            rdy    = 4'b1101;
            rdy[1] = (k % 2 == 0);
            if (rdy[1]) push(1);
            cyc_begin();
            check("bp_ready_mirror", ram_rdy, rdy[1]);
            check("bp_grant", grant, 4'b0010);
            cyc_end();
        end
        rdy = '1;
        cyc_begin();
        check("bp_release_ready", ram_rdy, 1'b0);
        check("bp_release_busy", busy, 1'b1);
        cyc_end();

        // Buffer drops after two samples to consumer 2; next grant goes to consumer 3.
        drive(4'b1111, 1'b1, 1'b1, '1);
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
        for (int i = 0; i < 2; i++) begin
            push(2);
            cyc_begin();
            check("drop_grant", grant, 4'b0100);
            cyc_end();
        end
        buf_rdy = 1'b0;
        cyc_begin();
        check("drop_ram_ready", ram_rdy, 1'b0);
        check("drop_cons_valid", cv, '0);
        cyc_end();
        buf_rdy = 1'b1;
        cyc_begin();
        check("drop_release_busy", busy, 1'b1);
        check("drop_release_ready", ram_rdy, 1'b0);
        cyc_end();
        cyc_begin();
        check("drop_idle_busy", busy, 1'b0);
        cyc_end();
        cyc_begin(); cyc_end();
        run_full_burst(3, "after_drop");
        idle_cycles(2);

        // Consumer 0 stalls with valid high.
        drive(4'b0001, 1'b1, 1'b1, 4'b1110);
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k <= TO; k++) begin
            cyc_begin();
            check("stall_grant", grant, 4'b0001);
            check("stall_timeout_pulse", tmo, (k == TO));
            cyc_end();
        end
        drive(4'b0011, 1'b1, 1'b1, '1);
        cyc_begin();
        check("timeout_release_pulse_gone", tmo, 1'b0);
        check("timeout_release_busy", busy, 1'b1);
        cyc_end();
`else
        for (int k = 0; k < 40; k++) begin
            cyc_begin();
            check("hold_grant", grant, 4'b0001);
            check("hold_no_timeout", tmo, 1'b0);
            cyc_end();
        end
        drive(4'b0000, 1'b1, 1'b1, 4'b1110);
        cyc_begin();
        check("hold_drop_busy", busy, 1'b1);
        cyc_end();
        drive(4'b0011, 1'b1, 1'b1, '1);
        cyc_begin();
        check("hold_release_ready", ram_rdy, 1'b0);
        cyc_end();
`endif
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
        run_full_burst(1, "after_stall");
        idle_cycles(2);

        // Reset asserted between edges in the first burst cycle of consumer 2.
        drive(4'b1111, 1'b1, 1'b1, '1);
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
        check("pre_reset_grant", grant, 4'b0100);
        check("pre_reset_ready", ram_rdy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_grant", grant, '0);
        check("async_reset_cons_valid", cv, '0);
        check("async_reset_ram_ready", ram_rdy, 1'b0);
        check("async_reset_busy", busy, 1'b0);
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
        #2;
        rst_n = 1'b1;
        cyc_begin();
        check("post_reset_idle", busy, 1'b0);
        cyc_end();
        cyc_begin(); cyc_end();
        run_full_burst(0, "post_reset");
        idle_cycles(2);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
